// File: rtl/bram_dmem.sv
// bram_dmem: single-port read-first byte-enabled data memory with valid/ready request and response channels.
module bram_dmem #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int OUT_REG    = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = DEPTH_LOG2 + OFF;
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] q, d1;
  logic [DEPTH_LOG2-1:0] idx;
  logic stall, acc, err, v1, e1;
  assign idx       = req_addr[AW-1:OFF];
  assign err       = (|req_addr[OFF-1:0]) || ((req_addr >> AW) != 32'd0);
  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !stall;
  assign acc       = req_valid && req_ready;
  // RAM enable drops during a stall, so q holds the word being presented
  always_ff @(posedge clk)
    if (rstn && acc && !err) begin
      q <= mem[idx];
      if (req_we)
        for (int i = 0; i < NB; i++)
          if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
    end
  always_ff @(posedge clk)
    if (!rstn) begin
      v1 <= 1'b0;
      e1 <= 1'b0;
    end else if (!stall) begin
      v1 <= req_valid;
      e1 <= req_valid && err;
    end
  assign d1 = (v1 && !e1) ? q : '0;
  generate
    if (OUT_REG != 0) begin : g_reg
      logic v2, e2;
      logic [DATA_W-1:0] d2;
      always_ff @(posedge clk)
        if (!rstn) begin
          v2 <= 1'b0;
          e2 <= 1'b0;
          d2 <= '0;
        end else if (!stall) begin
          v2 <= v1;
          e2 <= e1;
          d2 <= d1;
        end
      assign rsp_valid = v2;
      assign rsp_err   = e2;
      assign rsp_rdata = d2;
    end else begin : g_noreg
      assign rsp_valid = v1;
      assign rsp_err   = e1;
      assign rsp_rdata = d1;
    end
  endgenerate
endmodule
